// File: rtl/mem_stage_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_if
//   Bundle of the execute->MEM inputs and the MEM->WB / stall outputs of
//   mem_stage_lsu.
//   master : upstream / pipeline side (drives *_i, observes *_o)
//   slave  : the memory stage itself (observes *_i, drives *_o)
// ---------------------------------------------------------------------------
interface mem_stage_lsu_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid_i;
   logic                  ld_en_i;
   logic                  st_en_i;
   logic [2:0]            funct3_i;
   logic [DATA_WIDTH-1:0] opr_res_i;
   logic [DATA_WIDTH-1:0] opr_b_i;
   logic [4:0]            rd_i;
   logic [DATA_WIDTH-1:0] pc4_i;
   logic                  rf_en_i;
   logic [1:0]            wb_sel_i;

   logic                  stall_o;
   logic                  valid_o;
   logic [DATA_WIDTH-1:0] dmem_rdata_o;
   logic [DATA_WIDTH-1:0] opr_res_o;
   logic [4:0]            rd_o;
   logic [DATA_WIDTH-1:0] pc4_o;
   logic [1:0]            wb_sel_o;
   logic                  rf_en_o;
   logic                  misalign_o;

   modport master (
      output valid_i, ld_en_i, st_en_i, funct3_i, opr_res_i, opr_b_i,
             rd_i, pc4_i, rf_en_i, wb_sel_i,
      input  stall_o, valid_o, dmem_rdata_o, opr_res_o, rd_o, pc4_o,
             wb_sel_o, rf_en_o, misalign_o
   );

   modport slave (
      input  valid_i, ld_en_i, st_en_i, funct3_i, opr_res_i, opr_b_i,
             rd_i, pc4_i, rf_en_i, wb_sel_i,
      output stall_o, valid_o, dmem_rdata_o, opr_res_o, rd_o, pc4_o,
             wb_sel_o, rf_en_o, misalign_o
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   RISC-V memory stage with sub-word loads/stores, sign/zero extension,
//   byte-lane strobes, a configurable access latency with upstream stall,
//   and registered MEM/WB outputs.
//
//   Ports:
//     clk     : clock
//     arst_n  : asynchronous active-low reset
//     bus     : mem_stage_lsu_if.slave (execute-side inputs, WB outputs,
//               stall_o back to upstream)
//
//   Optional feature macro: MEM_STAGE_LSU_MISALIGN_CHK_EN
//     defined   : misaligned half/word/double accesses are flagged on
//                 misalign_o and make no memory access
//     undefined : misalign_o is 0, offsets are aligned down to access size
//
//   State | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no access in flight; L=0 accesses complete from here
//   WAIT  | counting down the remaining latency of an accepted access
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int DATA_WIDTH    = 32,
   parameter int DMEM_SZ_IN_KB = 1,
   parameter int DMEM_LATENCY  = 0
) (
   input logic               clk,
   input logic               arst_n,
   mem_stage_lsu_if.slave    bus
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFFW  = $clog2(NB);
   localparam int DEPTH = DMEM_SZ_IN_KB * 1024 / NB;
   localparam int IDXW  = $clog2(DEPTH);
   localparam logic [3:0] LAT_M1 = (DMEM_LATENCY > 0) ? 4'(DMEM_LATENCY - 1) : 4'd0;

   if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_dw
      $error("mem_stage_lsu: DATA_WIDTH must be 32 or 64");
   end
   if ((DMEM_LATENCY < 0) || (DMEM_LATENCY > 15)) begin : g_bad_lat
      $error("mem_stage_lsu: DMEM_LATENCY must be 0..15");
   end

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                r_state, w_state_nx;
   logic [3:0]            r_cnt, w_cnt_nx;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_is_st, w_is_ld, w_req, w_misalign, w_mem_op;
   logic                  w_fire, w_stall, w_we;
   logic [1:0]            w_sz;
   logic [OFFW-1:0]       w_off_raw, w_lowmask, w_off;
   logic [IDXW-1:0]       w_idx;
   logic [NB-1:0]         w_lanes, w_strb;
   logic [DATA_WIDTH-1:0] w_wdata, w_word, w_shift, w_mask, w_ext;
   logic                  w_sbit;

   logic                  r_valid, r_rf_en, r_misalign;
   logic [DATA_WIDTH-1:0] r_rdata, r_opr_res, r_pc4;
   logic [4:0]            r_rd;
   logic [1:0]            r_wb_sel;

   // Store wins when both enables are set.
   assign w_is_st = bus.st_en_i;
   assign w_is_ld = bus.ld_en_i & ~bus.st_en_i;
   assign w_req   = bus.valid_i & (bus.ld_en_i | bus.st_en_i);

   // log2 of access bytes; doubleword encodings fall back to word on RV32.
   assign w_sz = ((DATA_WIDTH == 32) && (bus.funct3_i[1:0] == 2'b11)) ?
                 2'b10 : bus.funct3_i[1:0];

   assign w_off_raw = bus.opr_res_i[OFFW-1:0];
   assign w_lowmask = OFFW'((4'd1 << w_sz) - 4'd1);

`ifdef MEM_STAGE_LSU_MISALIGN_CHK_EN
   assign w_misalign = w_req & (|(w_off_raw & w_lowmask));
   assign w_off      = w_off_raw;
`else
   assign w_misalign = 1'b0;
   assign w_off      = w_off_raw & ~w_lowmask;
`endif

   assign w_mem_op = w_req & ~w_misalign;
   assign w_idx    = bus.opr_res_i[OFFW +: IDXW];

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_fire     = 1'b0;
      w_stall    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               if (DMEM_LATENCY == 0) begin
                  w_fire = 1'b1;
               end else begin
                  w_stall    = 1'b1;
                  w_state_nx = S_WAIT;
                  w_cnt_nx   = LAT_M1;
               end
            end
         end
         S_WAIT: begin
            if (!w_mem_op) begin
               // upstream dropped the op; nothing left to complete
               w_state_nx = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_fire     = 1'b1;
               w_state_nx = S_IDLE;
            end else begin
               w_stall  = 1'b1;
               w_cnt_nx = r_cnt - 4'd1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign bus.stall_o = w_stall & arst_n;

   always_comb begin
      w_lanes = '0;
      case (w_sz)
         2'd0:    w_lanes = NB'(8'h01);
         2'd1:    w_lanes = NB'(8'h03);
         2'd2:    w_lanes = NB'(8'h0F);
         default: w_lanes = '1;
      endcase
   end

   assign w_strb  = w_lanes << w_off;
   assign w_wdata = bus.opr_b_i << {w_off, 3'b000};
   // Gating with arst_n keeps a store from landing while reset is held.
   assign w_we    = w_fire & w_is_st & arst_n;

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   assign w_word  = r_mem[w_idx];
   assign w_shift = w_word >> {w_off, 3'b000};

   always_comb begin
      w_mask = '1;
      w_sbit = 1'b0;
      case (w_sz)
         2'd0: begin
            w_mask = DATA_WIDTH'(8'hFF);
            w_sbit = w_shift[7];
         end
         2'd1: begin
            w_mask = DATA_WIDTH'(16'hFFFF);
            w_sbit = w_shift[15];
         end
         2'd2: begin
            w_mask = DATA_WIDTH'(32'hFFFF_FFFF);
            w_sbit = w_shift[31];
         end
         default: begin
            w_mask = '1;
            w_sbit = 1'b0;
         end
      endcase
      w_ext = (w_shift & w_mask) |
              ((w_sbit & ~bus.funct3_i[2]) ? ~w_mask : '0);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_valid    <= 1'b0;
         r_rf_en    <= 1'b0;
         r_misalign <= 1'b0;
         r_rdata    <= '0;
         r_opr_res  <= '0;
         r_pc4      <= '0;
         r_rd       <= 5'd0;
         r_wb_sel   <= 2'd0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         if (w_stall) begin
            // results are presented for a single cycle only
            r_valid <= 1'b0;
            r_rf_en <= 1'b0;
         end else begin
            r_valid    <= bus.valid_i;
            r_rf_en    <= bus.rf_en_i & bus.valid_i & ~w_misalign;
            r_misalign <= w_misalign;
            r_rdata    <= (w_fire & w_is_ld) ? w_ext : '0;
            r_opr_res  <= bus.opr_res_i;
            r_pc4      <= bus.pc4_i;
            r_rd       <= bus.rd_i;
            r_wb_sel   <= bus.wb_sel_i;
         end
      end
   end

   assign bus.valid_o      = r_valid;
   assign bus.rf_en_o      = r_rf_en;
   assign bus.misalign_o   = r_misalign;
   assign bus.dmem_rdata_o = r_rdata;
   assign bus.opr_res_o    = r_opr_res;
   assign bus.pc4_o        = r_pc4;
   assign bus.rd_o         = r_rd;
   assign bus.wb_sel_o     = r_wb_sel;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the single-cycle memory stage.
- Adds RISC-V sub-word loads and stores (byte/half/word, plus double when DATA_WIDTH=64), sign/zero extension and byte-lane write strobes.
- Adds a configurable data-memory access latency with a pipeline stall handshake, and registered MEM/WB outputs.
- Sits between the execute stage and the writeback stage.

Parameters:
- DATA_WIDTH, 32, datapath width; legal values are 32 or 64; any other value is an elaboration error.
- DMEM_SZ_IN_KB, 1, data memory size in KiB; depth = DMEM_SZ_IN_KB*1024/(DATA_WIDTH/8) words.
- DMEM_LATENCY, 0, number of extra stall cycles per load/store (0..15).

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- valid_i  in  1  instruction present in MEM
- ld_en_i  in  1  load
- st_en_i  in  1  store
- funct3_i  in  3  access size/sign (RISC-V encoding)
- opr_res_i  in  DATA_WIDTH  ALU result / byte address
- opr_b_i  in  DATA_WIDTH  store data
- rd_i  in  5  destination register
- pc4_i  in  DATA_WIDTH  PC+4
- rf_en_i  in  1  register-file write enable
- wb_sel_i  in  2  writeback select
- stall_o  out  1  hold upstream stages and inputs
- valid_o  out  1  result valid toward WB
- dmem_rdata_o  out  DATA_WIDTH  extended load data
- opr_res_o, rd_o, pc4_o, wb_sel_o  out  as inputs  registered pass-through
- rf_en_o  out  1  registered rf_en, qualified
- misalign_o  out  1  misaligned access flag

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. stall_o is 0 while arst_n is low. Memory contents are not reset.
- Memory op = valid_i & (ld_en_i | st_en_i). ld_en_i and st_en_i both high is treated as a store.
- Non-memory op: all *_o outputs are registered from the inputs on the next edge. valid_o = valid_i. Latency is 1 and there is no stall.
- Memory op presented in cycle T, with L = DMEM_LATENCY:
  - stall_o is high in cycles T..T+L-1 (combinational in cycle T).
  - Upstream holds the inputs stable through T+L.
  - At the edge closing cycle T+L, the store is committed or the load word is captured.
  - valid_o and the results appear in cycle T+L+1, for one cycle.
  - L=0 gives no stall and 1-cycle latency.
- FSM:
  - IDLE→WAIT on a memory op when L>0, with counter loaded to L-1.
  - WAIT decrements the counter. At 0, stall_o drops and the access completes at the next edge; then return to IDLE.
  - A new op presented in cycle T+L+1 is accepted normally (back-to-back).
- Addressing:
  - word index = opr_res_i[log2(DATA_WIDTH/8) +: log2(depth)]. Upper bits are ignored, so addresses wrap modulo the memory size.
  - Byte offset = low address bits.
- Store strobes from funct3:
  - 000 SB: 1 lane.
  - 001 SH: 2 lanes.
  - 010 SW: 4 lanes.
  - 011 SD: all 8 lanes (64-bit only).
  - Data is replicated or shifted to the addressed lanes. Unselected lanes are unchanged.
- Load extension from funct3:
  - 000 LB, 001 LH, 010 LW: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 011 LD: full width, 64-bit only.
  - On DATA_WIDTH=32, funct3 011 and 110 behave as word access.
- dmem_rdata_o is 0 for non-load ops.
- A read and write to the same word in the same op cannot occur. A load after a store returns the stored data.

Optional Feature:
- Macro: MEM_STAGE_LSU_MISALIGN_CHK_EN.
- Defined:
  - A half access with addr[0]≠0, a word access with addr[1:0]≠0, or a double access with addr[2:0]≠0 is flagged.
  - No memory access is made, no stall is raised, and the memory is unchanged.
  - The result is registered with misalign_o=1, rf_en_o=0 and dmem_rdata_o=0.
- Undefined:
  - misalign_o is tied 0.
  - The offset bits below the access size are forced to 0 (aligned down) and the access proceeds.

Test Plan:
- L=0, DW=32: SW 0xDEADBEEF @0x10, then LB @0x13 → rdata 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD. stall_o is never high.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 → 0xDEAD55EF, confirming the other lanes are intact.
- L=3: LW presented at T → stall_o high T..T+2, valid_o in T+4 only. A back-to-back SW at T+4 stalls T+4..T+6.
- Address 0x400+0x8 with 1 KiB reads the same word as 0x008 (wrap).
- With MEM_STAGE_LSU_MISALIGN_CHK_EN: LW @0x13 → misalign_o=1, rf_en_o=0, no stall. A subsequent LW @0x10 shows the memory unchanged.
- arst_n low in WAIT mid-store (L=4) → outputs 0, FSM IDLE, target word not written. Read back returns the old value.
